// File: rtl/reorder_buffer_if.sv
// Dispatch / writeback / retire bundle for the reorder buffer.
//   alloc_*  : dispatch side, up to DISP_WIDTH program-ordered allocations
//   wb_*     : one completion strobe per execution pipe
//   retire_* : up to RETIRE_WIDTH in-order commits
//   flush*   : one-cycle pipeline flush with cause and offending pc
//   rob_count: occupied entries
// slave = ROB side, master = dispatch/execute/commit consumers.
interface reorder_buffer_if #(
  parameter int NUM_ROB_ENTS = 64,
  parameter int DISP_WIDTH   = 2,
  parameter int RETIRE_WIDTH = 4,
  parameter int NUM_FUS      = 4,
  parameter int NUM_AREGS    = 32,
  parameter int NUM_PREGS    = 128
);
  localparam int IDX_W  = $clog2(NUM_ROB_ENTS);
  localparam int CNT_W  = IDX_W + 1;
  localparam int AREG_W = $clog2(NUM_AREGS);
  localparam int PREG_W = $clog2(NUM_PREGS);

  logic [DISP_WIDTH-1:0]                 alloc_valid;
  logic [DISP_WIDTH-1:0][AREG_W-1:0]     alloc_dst_areg;
  logic [DISP_WIDTH-1:0][PREG_W-1:0]     alloc_dst_preg;
  logic [DISP_WIDTH-1:0][31:0]           alloc_pc;
  logic                                  alloc_ready;
  logic [DISP_WIDTH-1:0][IDX_W-1:0]      alloc_idx;

  logic [NUM_FUS-1:0]                    wb_valid;
  logic [NUM_FUS-1:0][IDX_W-1:0]         wb_rob_idx;
  logic [NUM_FUS-1:0]                    wb_exception;
  logic [NUM_FUS-1:0]                    wb_br_mispred;

  logic [RETIRE_WIDTH-1:0]               retire_valid;
  logic [RETIRE_WIDTH-1:0][AREG_W-1:0]   retire_dst_areg;
  logic [RETIRE_WIDTH-1:0][PREG_W-1:0]   retire_dst_preg;
  logic [RETIRE_WIDTH-1:0][31:0]         retire_pc;

  logic                                  flush;
  logic                                  flush_exception;
  logic [31:0]                           flush_pc;
  logic [CNT_W-1:0]                      rob_count;

  modport slave (
    input  alloc_valid, alloc_dst_areg, alloc_dst_preg, alloc_pc,
    input  wb_valid, wb_rob_idx, wb_exception, wb_br_mispred,
    output alloc_ready, alloc_idx,
    output retire_valid, retire_dst_areg, retire_dst_preg, retire_pc,
    output flush, flush_exception, flush_pc, rob_count
  );

  modport master (
    output alloc_valid, alloc_dst_areg, alloc_dst_preg, alloc_pc,
    output wb_valid, wb_rob_idx, wb_exception, wb_br_mispred,
    input  alloc_ready, alloc_idx,
    input  retire_valid, retire_dst_areg, retire_dst_preg, retire_pc,
    input  flush, flush_exception, flush_pc, rob_count
  );
endinterface

// File: rtl/reorder_buffer.sv
// In-order commit stage. Allocates up to DISP_WIDTH entries per cycle at the
// tail, marks entries done out of order from NUM_FUS writeback ports, retires
// up to RETIRE_WIDTH done entries per cycle from the head, and raises a
// one-cycle flush on a mispredicted branch (retired) or an exception (not
// retired). Retire/flush outputs are registered.
// Ports: clk, rst (sync, active-high), bus (reorder_buffer_if.slave).

// One retire lane: decides whether the entry at head+k commits and whether
// it terminates the scan.
module rob_retire_lane (
  input  logic i_go,        // all older lanes retired without stopping
  input  logic i_valid,
  input  logic i_done,
  input  logic i_exc,
  input  logic i_mis,
  output logic o_retire,
  output logic o_stop_exc,
  output logic o_stop_mis
);
  logic w_ready;
  assign w_ready    = i_go & i_valid & i_done;
  assign o_retire   = w_ready & ~i_exc;
  assign o_stop_exc = w_ready & i_exc;
  // a mispredicted branch itself commits; younger lanes are wrong-path
  assign o_stop_mis = o_retire & i_mis;
endmodule

module reorder_buffer #(
  parameter int NUM_ROB_ENTS = 64,
  parameter int DISP_WIDTH   = 2,
  parameter int RETIRE_WIDTH = 4,
  parameter int NUM_FUS      = 4,
  parameter int NUM_AREGS    = 32,
  parameter int NUM_PREGS    = 128
) (
  input  logic              clk,
  input  logic              rst,
  reorder_buffer_if.slave   bus
);
  localparam int IDX_W  = $clog2(NUM_ROB_ENTS);
  localparam int CNT_W  = IDX_W + 1;
  localparam int AREG_W = $clog2(NUM_AREGS);
  localparam int PREG_W = $clog2(NUM_PREGS);
  typedef logic [IDX_W-1:0] idx_t;

  // entry state
  logic [NUM_ROB_ENTS-1:0] r_valid, r_done, r_exc, r_mis;
  logic [AREG_W-1:0]       r_areg [NUM_ROB_ENTS];
  logic [PREG_W-1:0]       r_preg [NUM_ROB_ENTS];
  logic [31:0]             r_pc   [NUM_ROB_ENTS];
  idx_t                    r_head, r_tail;
  logic [CNT_W-1:0]        r_count;

  // registered outputs
  logic [RETIRE_WIDTH-1:0]             r_ret_valid;
  logic [RETIRE_WIDTH-1:0][AREG_W-1:0] r_ret_areg;
  logic [RETIRE_WIDTH-1:0][PREG_W-1:0] r_ret_preg;
  logic [RETIRE_WIDTH-1:0][31:0]       r_ret_pc;
  logic                                r_flush, r_flush_exc;
  logic [31:0]                         r_flush_pc;

  // ---------------- allocate ----------------
  // Space comes from the registered count only; same-cycle retires do not help.
  logic                             w_alloc_ready;
  logic [DISP_WIDTH-1:0]            w_alloc_go;
  logic [DISP_WIDTH-1:0][IDX_W-1:0] w_alloc_idx;
  logic [CNT_W-1:0]                 w_alloc_n;
  logic [DISP_WIDTH-1:0]            w_av_inc;

  assign w_alloc_ready = (r_count <= CNT_W'(NUM_ROB_ENTS - DISP_WIDTH)) && !r_flush;
  assign w_alloc_go    = bus.alloc_valid & {DISP_WIDTH{w_alloc_ready}};

  genvar gk;
  generate
    for (gk = 0; gk < DISP_WIDTH; gk++) begin : g_aidx
      assign w_alloc_idx[gk] = r_tail + idx_t'(gk);
    end
  endgenerate

  always_comb begin
    w_alloc_n = '0;
    for (int k = 0; k < DISP_WIDTH; k++) w_alloc_n = w_alloc_n + CNT_W'(w_alloc_go[k]);
  end

  // ---------------- writeback decode ----------------
  // Ports hitting the same entry OR their flags together.
  logic [NUM_ROB_ENTS-1:0] w_wb_hit, w_wb_exc, w_wb_mis;
  always_comb begin
    w_wb_hit = '0;
    w_wb_exc = '0;
    w_wb_mis = '0;
    for (int p = 0; p < NUM_FUS; p++) begin
      if (bus.wb_valid[p]) begin
        w_wb_hit[bus.wb_rob_idx[p]] = 1'b1;
        w_wb_exc[bus.wb_rob_idx[p]] = w_wb_exc[bus.wb_rob_idx[p]] | bus.wb_exception[p];
        w_wb_mis[bus.wb_rob_idx[p]] = w_wb_mis[bus.wb_rob_idx[p]] | bus.wb_br_mispred[p];
      end
    end
  end

  // ---------------- retire select ----------------
  logic [RETIRE_WIDTH-1:0]            w_go, w_ret, w_stop_exc, w_stop_mis;
  logic [RETIRE_WIDTH-1:0][IDX_W-1:0] w_ret_idx;
  logic [CNT_W-1:0]                   w_ret_n;
  logic                               w_flush, w_flush_exc;
  logic [31:0]                        w_flush_pc;

  assign w_go[0] = 1'b1;
  generate
    for (gk = 0; gk < RETIRE_WIDTH; gk++) begin : g_lane
      assign w_ret_idx[gk] = r_head + idx_t'(gk);
      rob_retire_lane u_lane (
        .i_go       (w_go[gk]),
        .i_valid    (r_valid[w_ret_idx[gk]]),
        .i_done     (r_done[w_ret_idx[gk]]),
        .i_exc      (r_exc[w_ret_idx[gk]]),
        .i_mis      (r_mis[w_ret_idx[gk]]),
        .o_retire   (w_ret[gk]),
        .o_stop_exc (w_stop_exc[gk]),
        .o_stop_mis (w_stop_mis[gk])
      );
      if (gk < RETIRE_WIDTH-1) begin : g_chain
        assign w_go[gk+1] = w_ret[gk] & ~w_stop_mis[gk];
      end
    end
  endgenerate

  // the scan stops at the first flush source, so at most one lane is set
  assign w_flush     = |(w_stop_exc | w_stop_mis);
  assign w_flush_exc = |w_stop_exc;

  always_comb begin
    w_flush_pc = '0;
    w_ret_n    = '0;
    for (int k = 0; k < RETIRE_WIDTH; k++) begin
      if (w_stop_exc[k] | w_stop_mis[k]) w_flush_pc = r_pc[w_ret_idx[k]];
      w_ret_n = w_ret_n + CNT_W'(w_ret[k]);
    end
  end

  // ---------------- state update ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_valid     <= '0;
      r_done      <= '0;
      r_exc       <= '0;
      r_mis       <= '0;
      r_ret_valid <= '0;
      r_ret_areg  <= '0;
      r_ret_preg  <= '0;
      r_ret_pc    <= '0;
      r_flush     <= 1'b0;
      r_flush_exc <= 1'b0;
      r_flush_pc  <= '0;
    end else begin
      r_ret_valid <= w_ret;
      for (int k = 0; k < RETIRE_WIDTH; k++) begin
        r_ret_areg[k] <= r_areg[w_ret_idx[k]];
        r_ret_preg[k] <= r_preg[w_ret_idx[k]];
        r_ret_pc[k]   <= r_pc[w_ret_idx[k]];
      end
      r_flush     <= w_flush;
      r_flush_exc <= w_flush_exc;
      r_flush_pc  <= w_flush_pc;

      if (w_flush) begin
        // same-cycle allocations and writebacks are discarded
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
        r_valid <= '0;
        r_done  <= '0;
      end else begin
        // writebacks to unallocated entries are dropped
        r_done <= r_done | (w_wb_hit & r_valid);
        r_exc  <= r_exc  | (w_wb_exc & r_valid);
        r_mis  <= r_mis  | (w_wb_mis & r_valid);
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
          if (w_ret[k]) begin
            r_valid[w_ret_idx[k]] <= 1'b0;
            r_done[w_ret_idx[k]]  <= 1'b0;
          end
        end
        for (int k = 0; k < DISP_WIDTH; k++) begin
          if (w_alloc_go[k]) begin
            r_valid[w_alloc_idx[k]] <= 1'b1;
            r_done[w_alloc_idx[k]]  <= 1'b0;
            r_exc[w_alloc_idx[k]]   <= 1'b0;
            r_mis[w_alloc_idx[k]]   <= 1'b0;
          end
        end
        r_head  <= r_head + idx_t'(w_ret_n);
        r_tail  <= r_tail + idx_t'(w_alloc_n);
        r_count <= r_count + w_alloc_n - w_ret_n;
      end
    end
  end

  // payload storage needs no reset; valid/done gate every use
  always_ff @(posedge clk) begin
    for (int k = 0; k < DISP_WIDTH; k++) begin
      if (!rst && !w_flush && w_alloc_go[k]) begin
        r_areg[w_alloc_idx[k]] <= bus.alloc_dst_areg[k];
        r_preg[w_alloc_idx[k]] <= bus.alloc_dst_preg[k];
        r_pc[w_alloc_idx[k]]   <= bus.alloc_pc[k];
      end
    end
  end

  // alloc_valid must be a contiguous run starting at slot 0
  assign w_av_inc = bus.alloc_valid + DISP_WIDTH'(1);
  a_alloc_contig: assert property (@(posedge clk) disable iff (rst)
    ((bus.alloc_valid & w_av_inc) == '0));

  // ---------------- outputs ----------------
  assign bus.alloc_ready     = w_alloc_ready;
  assign bus.alloc_idx       = w_alloc_idx;
  assign bus.retire_valid    = r_ret_valid;
  assign bus.retire_dst_areg = r_ret_areg;
  assign bus.retire_dst_preg = r_ret_preg;
  assign bus.retire_pc       = r_ret_pc;
  assign bus.flush           = r_flush;
  assign bus.flush_exception = r_flush_exc;
  assign bus.flush_pc        = r_flush_pc;
  assign bus.rob_count       = r_count;
endmodule
